// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control/handshake bundle between the multicycle sequencer and its datapath.
interface multicycle_control_fsm_if;
    logic [6:0]  Opcode;
    logic        MemReady;
    logic        MemReq;
    logic        MemWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        ResultSrc;
    logic        RegWrite;
    logic        Illegal;
    logic        BusError;
    logic [31:0] InstrCount;
    modport master (
        input  Opcode, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ALUOp,
               ResultSrc, RegWrite, Illegal, BusError, InstrCount
    );
    modport slave (
        output Opcode, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ALUOp,
               ResultSrc, RegWrite, Illegal, BusError, InstrCount
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: fetch/decode/execute/writeback sequencer with memory handshake watchdog.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic clk,
    input logic reset,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMREAD, MEMWRITE, ALUWB, MEMWB, ILLEGAL
    } state_t;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic mem_state, timeout, retire;
    assign mem_state = state == FETCH || state == MEMREAD || state == MEMWRITE;
    // MemReady on the last allowed cycle still completes the access
    assign timeout = mem_state && !bus.MemReady && wait_cnt == LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.InstrCount <= '0;
        end else begin
            state          <= state_next;
            wait_cnt       <= (mem_state && !bus.MemReady && !timeout) ? wait_cnt + 1'b1 : '0;
            bus.InstrCount <= bus.InstrCount + {31'b0, retire};
        end
    always_comb begin
        state_next    = state;
        retire        = 1'b0;
        bus.MemReq    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.ResultSrc = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.Illegal   = 1'b0;
        bus.BusError  = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                bus.MemReq = 1'b1;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 2'b01;
                    state_next  = DECODE;
                end
            end
            DECODE: state_next = bus.Opcode == OP_R  ? EXEC_R :
                                 bus.Opcode == OP_I  ? EXEC_I :
                                 (bus.Opcode == OP_LW || bus.Opcode == OP_SW) ? MEMADR : ILLEGAL;
            EXEC_R: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUOp   = 2'b10;
                state_next  = ALUWB;
            end
            EXEC_I: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                state_next  = ALUWB;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b01;
                state_next  = bus.Opcode == OP_SW ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.MemReq = 1'b1;
                bus.AdrSrc = 1'b1;
                if (bus.MemReady) state_next = MEMWB;
            end
            MEMWRITE: begin
                bus.MemReq   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.MemReady) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                state_next   = FETCH;
                retire       = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite  = 1'b1;
                bus.ResultSrc = 1'b1;
                state_next    = FETCH;
                retire        = 1'b1;
            end
            ILLEGAL: begin
                bus.Illegal = 1'b1;
                state_next  = FETCH;
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            bus.BusError = 1'b1;
            state_next   = FETCH;
        end
    end
endmodule
